screen_sequencer: RTL and testbench

Parametrised screen-flow controller for the Snake VGA front end. It sequences title, play, pause and game-over screens and drives the framebuffer fill engine with a screen-select code, write enable and a self-generated pixel address. It gates the game core through `go`. It adds pause, edge-detected start, bounded game-over flashing and exact-length fills.

---
 rtl/snake_screen_pkg.sv | 54 +++++
 rtl/screen_sequencer_edge_rise.sv | 32 +++
 rtl/screen_sequencer.sv | 167 ++++++++++++++++
 tb/tb_screen_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_screen_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// snake_screen_pkg
// Shared definitions for the Snake VGA screen flow:
//   - screen_sel encoding used by the sequencer and the fill-engine decoder
//   - screen sequencer state enum
//   - default fill geometry (160x120 pixels)
//   - helpers decoding a state into its fill source / write enable
// -----------------------------------------------------------------------------
package snake_screen_pkg;

   localparam int PIXELS_DEF = 19200;
   localparam int ADDR_W_DEF = 15;

   localparam logic [2:0] SEL_NONE     = 3'd0;
   localparam logic [2:0] SEL_TITLE    = 3'd1;
   localparam logic [2:0] SEL_BLACK    = 3'd2;
   localparam logic [2:0] SEL_GAMEOVER = 3'd3;
   localparam logic [2:0] SEL_RED      = 3'd4;
   localparam logic [2:0] SEL_PAUSED   = 3'd5;

   typedef enum logic [3:0] {
      ST_DRAW_TITLE = 4'd0,
      ST_TITLE      = 4'd1,
      ST_DRAW_BLACK = 4'd2,
      ST_PLAY       = 4'd3,
      ST_DRAW_PAUSE = 4'd4,
      ST_PAUSED     = 4'd5,
      ST_DRAW_OVER  = 4'd6,
      ST_OVER_WAIT  = 4'd7,
      ST_DRAW_RED   = 4'd8,
      ST_RED_WAIT   = 4'd9
   } state_t;

   // Fill source for a state; wait states select nothing.
   function automatic logic [2:0] state_sel(input state_t st);
      logic [2:0] sel;
      case (st)
         ST_DRAW_TITLE: sel = SEL_TITLE;
         ST_DRAW_BLACK: sel = SEL_BLACK;
         ST_DRAW_PAUSE: sel = SEL_PAUSED;
         ST_DRAW_OVER:  sel = SEL_GAMEOVER;
         ST_DRAW_RED:   sel = SEL_RED;
         default:       sel = SEL_NONE;
      endcase
      return sel;
   endfunction

   // True for every DRAW_* state, i.e. whenever the framebuffer is written.
   function automatic logic is_draw(input state_t st);
      return (state_sel(st) != SEL_NONE);
   endfunction

endpackage

// File: rtl/screen_sequencer_edge_rise.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// edge_rise
// One-bit rising-edge detector: rise is high while d is high and the previous
// sampled value was low, so a held level produces a single pulse.
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-low reset (history register cleared)
//   d    in  button level
//   rise out d & ~d_q
// -----------------------------------------------------------------------------
module edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic d_q_r;

   // Previous-cycle sample of the button level.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_q_r <= 1'b0;
      end else begin
         d_q_r <= d;
      end
   end

   assign rise = d & ~d_q_r;

endmodule

// File: rtl/screen_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// screen_sequencer
// Screen-flow controller for the Snake VGA front end. Sequences title, play,
// pause and game-over screens, drives the framebuffer fill engine with a
// screen-select code, write enable and pixel address, and gates the game core.
// Parameters:
//   PIXELS   pixels per full-screen fill
//   ADDR_W   address width (2**ADDR_W >= PIXELS)
//   FLASHES  red flashes before returning to title; 0 = flash until start
// Ports:
//   clk        in  system clock
//   rst        in  asynchronous active-low reset
//   start      in  start/restart button level
//   pause      in  pause toggle button level
//   isDead     in  game core death flag
//   tick       in  one-cycle flash-rate strobe
//   screen_sel out fill source (see snake_screen_pkg)
//   addr       out pixel write address
//   wren       out framebuffer write enable
//   go         out game core run enable
// -----------------------------------------------------------------------------
module screen_sequencer
   import snake_screen_pkg::*;
#(
   parameter int PIXELS  = PIXELS_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter int FLASHES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pause,
   input  logic              isDead,
   input  logic              tick,
   output logic [2:0]        screen_sel,
   output logic [ADDR_W-1:0] addr,
   output logic              wren,
   output logic              go
);

   // Counter must be able to hold FLASHES itself.
   localparam int FC_W = (FLASHES == 0) ? 1 : $clog2(FLASHES + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

   state_t            state_r;
   state_t            state_next_s;
   logic [ADDR_W-1:0] addr_r;
   logic [ADDR_W-1:0] addr_next_s;
   logic [FC_W-1:0]   flash_cnt_r;
   logic [FC_W-1:0]   flash_cnt_next_s;
   logic              start_rise_s;
   logic              pause_rise_s;
   logic              wren_s;
   logic              fill_done_s;
   logic              flash_limit_s;

   edge_rise u_start_rise (
      .clk  (clk),
      .rst  (rst),
      .d    (start),
      .rise (start_rise_s)
   );

   edge_rise u_pause_rise (
      .clk  (clk),
      .rst  (rst),
      .d    (pause),
      .rise (pause_rise_s)
   );

   assign wren_s        = is_draw(state_r);
   assign fill_done_s   = wren_s && (addr_r == LAST_ADDR);
   assign flash_limit_s = (FLASHES != 0) && (flash_cnt_r == FC_W'(FLASHES));

   // Next-state logic; buttons and tick are only looked at in wait states.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_DRAW_TITLE: begin
            if (fill_done_s) state_next_s = ST_TITLE;
            else             state_next_s = state_r;
         end
         ST_TITLE: begin
            if (start_rise_s) state_next_s = ST_DRAW_BLACK;
            else              state_next_s = state_r;
         end
         ST_DRAW_BLACK: begin
            if (fill_done_s) state_next_s = ST_PLAY;
            else             state_next_s = state_r;
         end
         ST_PLAY: begin
            // Death outranks a simultaneous pause press.
            if (isDead)            state_next_s = ST_DRAW_OVER;
            else if (pause_rise_s) state_next_s = ST_DRAW_PAUSE;
            else                   state_next_s = state_r;
         end
         ST_DRAW_PAUSE: begin
            if (fill_done_s) state_next_s = ST_PAUSED;
            else             state_next_s = state_r;
         end
         ST_PAUSED: begin
            // Resume repaints black; the core redraws its field while go=0.
            if (pause_rise_s) state_next_s = ST_DRAW_BLACK;
            else              state_next_s = state_r;
         end
         ST_DRAW_OVER: begin
            if (fill_done_s) state_next_s = ST_OVER_WAIT;
            else             state_next_s = state_r;
         end
         ST_OVER_WAIT: begin
            if (start_rise_s) state_next_s = ST_DRAW_TITLE;
            else if (tick)    state_next_s = ST_DRAW_RED;
            else              state_next_s = state_r;
         end
         ST_DRAW_RED: begin
            if (fill_done_s) state_next_s = ST_RED_WAIT;
            else             state_next_s = state_r;
         end
         ST_RED_WAIT: begin
            // flash_cnt already counts the red fill just completed.
            if (start_rise_s)              state_next_s = ST_DRAW_TITLE;
            else if (tick && flash_limit_s) state_next_s = ST_DRAW_TITLE;
            else if (tick)                 state_next_s = ST_DRAW_OVER;
            else                           state_next_s = state_r;
         end
         default: state_next_s = ST_DRAW_TITLE;
      endcase
   end

   // Address and flash counter next values.
   always_comb begin
      addr_next_s      = addr_r;
      flash_cnt_next_s = flash_cnt_r;
      // Every state change starts the next fill from pixel 0.
      if (state_next_s != state_r) addr_next_s = '0;
      else if (fill_done_s)        addr_next_s = '0;
      else if (wren_s)             addr_next_s = addr_r + 1'b1;
      else                         addr_next_s = '0;

      if ((state_next_s == ST_DRAW_TITLE) && (state_r != ST_DRAW_TITLE))
         flash_cnt_next_s = '0;
      else if ((state_r == ST_DRAW_RED) && fill_done_s)
         flash_cnt_next_s = flash_cnt_r + 1'b1;
      else
         flash_cnt_next_s = flash_cnt_r;
   end

   // State, address and flash counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_DRAW_TITLE;
         addr_r      <= '0;
         flash_cnt_r <= '0;
      end else begin
         state_r     <= state_next_s;
         addr_r      <= addr_next_s;
         flash_cnt_r <= flash_cnt_next_s;
      end
   end

   assign screen_sel = state_sel(state_r);
   assign wren       = wren_s;
   assign go         = (state_r == ST_PLAY);
   assign addr       = addr_r;

endmodule

// File: tb/tb_screen_sequencer.sv
`timescale 1ns/1ps
// Directed bench for screen_sequencer with PIXELS=16, FLASHES=2.
module tb_screen_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       pause;
   logic       is_dead;
   logic       tick;
   logic [2:0] screen_sel;
   logic [3:0] addr;
   logic       wren;
   logic       go;

   int checks;
   int failures;

   screen_sequencer #(
      .PIXELS  (16),
      .ADDR_W  (4),
      .FLASHES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .pause      (pause),
      .isDead     (is_dead),
      .tick       (tick),
      .screen_sel (screen_sel),
      .addr       (addr),
      .wren       (wren),
      .go         (go)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0; start = 1'b0; pause = 1'b0; is_dead = 1'b0; tick = 1'b0;
      step; step;
      checks++;
      if (wren !== 1'b1 || screen_sel !== 3'd1 || go !== 1'b0 || addr !== 4'd0) begin
         failures++;
         $display("FAIL reset_outputs: wren=%0b sel=%0d go=%0b addr=%0d required wren=1 sel=1 go=0 addr=0",
                  wren, screen_sel, go, addr);
      end
      #2 rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (wren !== 1'b1 || screen_sel !== 3'd1 || addr !== 4'(i)) begin
            failures++;
            $display("FAIL title_fill[%0d]: wren=%0b sel=%0d addr=%0d required 1/1/%0d", i, wren, screen_sel, addr, i);
         end
         step;
      end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (wren !== 1'b0 || screen_sel !== 3'd0 || go !== 1'b0 || addr !== 4'd0) begin
            failures++;
            $display("FAIL title_idle[%0d]: wren=%0b sel=%0d go=%0b addr=%0d required 0/0/0/0", i, wren, screen_sel, go, addr);
         end
         step;
      end
   endtask

   task automatic test_start_held;
      start = 1'b1;
      step;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (wren !== 1'b1 || screen_sel !== 3'd2 || go !== 1'b0 || addr !== 4'(i)) begin
            failures++;
            $display("FAIL black_fill[%0d]: wren=%0b sel=%0d go=%0b addr=%0d required 1/2/0/%0d", i, wren, screen_sel, go, addr, i);
         end
         step;
      end
      for (int i = 17; i < 100; i++) begin
         checks++;
         if (wren !== 1'b0 || go !== 1'b1) begin
            failures++;
            $display("FAIL start_held_play[%0d]: wren=%0b go=%0b required wren=0 go=1", i, wren, go);
         end
         step;
      end
      start = 1'b0;
      step;
   endtask

   task automatic test_pause_toggle;
      pause = 1'b1;
      step;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (wren !== 1'b1 || screen_sel !== 3'd5 || go !== 1'b0 || addr !== 4'(i)) begin
            failures++;
            $display("FAIL pause_fill[%0d]: wren=%0b sel=%0d go=%0b addr=%0d required 1/5/0/%0d", i, wren, screen_sel, go, addr, i);
         end
         step;
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (wren !== 1'b0 || screen_sel !== 3'd0 || go !== 1'b0) begin
            failures++;
            $display("FAIL paused_idle[%0d]: wren=%0b sel=%0d go=%0b required 0/0/0", i, wren, screen_sel, go);
         end
         step;
      end
      pause = 1'b0;
      step;
      pause = 1'b1;
      step;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (wren !== 1'b1 || screen_sel !== 3'd2 || go !== 1'b0 || addr !== 4'(i)) begin
            failures++;
            $display("FAIL resume_fill[%0d]: wren=%0b sel=%0d go=%0b addr=%0d required 1/2/0/%0d", i, wren, screen_sel, go, addr, i);
         end
         step;
      end
      pause = 1'b0;
      checks++;
      if (go !== 1'b1 || wren !== 1'b0) begin
         failures++;
         $display("FAIL resume_play: go=%0b wren=%0b required go=1 wren=0", go, wren);
      end
      step;
   endtask

   task automatic test_dead_priority;
      pause = 1'b1;
      is_dead = 1'b1;
      step;
      checks++;
      if (screen_sel !== 3'd3 || wren !== 1'b1 || go !== 1'b0 || addr !== 4'd0) begin
         failures++;
         $display("FAIL dead_priority: sel=%0d wren=%0b go=%0b addr=%0d required sel=3 wren=1 go=0 addr=0",
                  screen_sel, wren, go, addr);
      end
      pause = 1'b0;
      is_dead = 1'b0;
   endtask

   // Continues from the first cycle of the game-over fill.
   task automatic test_flash;
      int  sels[$];
      int  lens[$];
      int  exp_sel[5];
      int  run_len;
      logic prev_wren;
      bit  done;
      exp_sel = '{3, 4, 3, 4, 1};
      run_len = 0;
      prev_wren = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 600 && !done; c++) begin
         if (wren === 1'b1) begin
            if (!prev_wren) sels.push_back(int'(screen_sel));
            checks++;
            if (addr !== 4'(run_len) || int'(screen_sel) != sels[$]) begin
               failures++;
               $display("FAIL flash_fill_addr: addr=%0d sel=%0d required addr=%0d sel=%0d", addr, screen_sel, run_len, sels[$]);
            end
            run_len++;
         end else if (prev_wren) begin
            lens.push_back(run_len);
            run_len = 0;
            if (lens.size() == 5) done = 1'b1;
         end
         prev_wren = wren;
         tick = ((c % 40) == 39);
         step;
      end
      tick = 1'b0;
      checks++;
      if (!done || sels.size() != 5) begin
         failures++;
         $display("FAIL flash_sequence_len: fills=%0d done=%0b required fills=5 done=1", sels.size(), done);
      end
      for (int i = 0; i < 5 && i < sels.size() && i < lens.size(); i++) begin
         checks++;
         if (sels[i] != exp_sel[i] || lens[i] != 16) begin
            failures++;
            $display("FAIL flash_fill[%0d]: sel=%0d len=%0d required sel=%0d len=16", i, sels[i], lens[i], exp_sel[i]);
         end
      end
      for (int c = 0; c < 90; c++) begin
         tick = ((c % 40) == 39);
         step;
         checks++;
         if (wren !== 1'b0 || go !== 1'b0) begin
            failures++;
            $display("FAIL title_after_flash[%0d]: wren=%0b go=%0b required 0/0", c, wren, go);
         end
      end
      tick = 1'b0;
   endtask

   task automatic test_async_reset;
      start = 1'b1;
      step;
      start = 1'b0;
      repeat (16) step;
      is_dead = 1'b1;
      step;
      is_dead = 1'b0;
      repeat (16) step;
      tick = 1'b1; step; tick = 1'b0;
      repeat (16) step;
      tick = 1'b1; step; tick = 1'b0;
      repeat (16) step;
      tick = 1'b1; step; tick = 1'b0;
      repeat (7) step;
      checks++;
      if (screen_sel !== 3'd4 || addr !== 4'd7 || dut.flash_cnt_r !== 2'd1) begin
         failures++;
         $display("FAIL red_precondition: sel=%0d addr=%0d flash_cnt=%0d required sel=4 addr=7 flash_cnt=1",
                  screen_sel, addr, dut.flash_cnt_r);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (addr !== 4'd0 || screen_sel !== 3'd1 || wren !== 1'b1 || go !== 1'b0 || dut.flash_cnt_r !== 2'd0) begin
         failures++;
         $display("FAIL async_reset: addr=%0d sel=%0d wren=%0b go=%0b flash_cnt=%0d required 0/1/1/0/0",
                  addr, screen_sel, wren, go, dut.flash_cnt_r);
      end
      #2 rst = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (wren !== 1'b1 || screen_sel !== 3'd1 || addr !== 4'(i)) begin
            failures++;
            $display("FAIL refill_title[%0d]: wren=%0b sel=%0d addr=%0d required 1/1/%0d", i, wren, screen_sel, addr, i);
         end
         step;
      end
      checks++;
      if (wren !== 1'b0 || screen_sel !== 3'd0) begin
         failures++;
         $display("FAIL refill_done: wren=%0b sel=%0d required 0/0", wren, screen_sel);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset;
      test_start_held;
      test_pause_toggle;
      test_dead_priority;
      test_flash;
      test_async_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
